// File: rtl/bsg_fifo_1rw_pkg.sv
// rtl/bsg_fifo_1rw_pkg.sv - op encoding and width helper for the 1RW FIFO scheduler
package bsg_fifo_1rw_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2
  } op_e;

  // Bit width needed to index n distinct values, never narrower than one bit.
  function automatic int lg_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_fifo_1rw_sched_if.sv
// rtl/bsg_fifo_1rw_sched_if.sv - enqueue, dequeue and SRAM signal bundle of the scheduler
interface bsg_fifo_1rw_sched_if #(
  parameter int width_p  = 256,
  parameter int addr_w_p = 9
);
  logic                enq_v_i;
  logic [width_p-1:0]  enq_data_i;
  logic                enq_yumi_o;
  logic                deq_ready_i;
  logic                deq_v_o;
  logic [width_p-1:0]  deq_data_o;
  logic                mem_v_o;
  logic                mem_w_o;
  logic [addr_w_p-1:0] mem_addr_o;
  logic [width_p-1:0]  mem_data_o;
  logic [width_p-1:0]  mem_data_i;
  logic                full_o;
  logic                empty_o;

  modport slave (
    input  enq_v_i, enq_data_i, deq_ready_i, mem_data_i,
    output enq_yumi_o, deq_v_o, deq_data_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o,
           full_o, empty_o
  );

  modport master (
    output enq_v_i, enq_data_i, deq_ready_i, mem_data_i,
    input  enq_yumi_o, deq_v_o, deq_data_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o,
           full_o, empty_o
  );
endinterface

// File: rtl/bsg_fifo_1rw_wrap_ptr.sv
// rtl/bsg_fifo_1rw_wrap_ptr.sv - modulo-els_p pointer, wraps by compare so any depth works
module bsg_fifo_1rw_wrap_ptr
  import bsg_fifo_1rw_pkg::*;
#(
  parameter int els_p = 4,
  localparam int w_lp = lg_f(els_p)
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic            inc_i,
  output logic [w_lp-1:0] ptr_o
);
  localparam logic [w_lp-1:0] last_lp = w_lp'(els_p - 1);

  logic [w_lp-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = (ptr_q == last_lp) ? '0 : ptr_q + w_lp'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ptr_q <= '0;
    else            ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;
endmodule

// File: rtl/bsg_fifo_1rw_sched.sv
// rtl/bsg_fifo_1rw_sched.sv - shares one 1RW SRAM between an enqueue and a dequeue stream
module bsg_fifo_1rw_sched
  import bsg_fifo_1rw_pkg::*;
#(
  parameter int els_p          = 512,
  parameter int width_p        = 256,
  parameter int starve_limit_p = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  bsg_fifo_1rw_sched_if.slave  io
);
  localparam int addr_w_lp   = lg_f(els_p);
  localparam int cnt_w_lp    = lg_f(els_p + 1);
  localparam int starve_w_lp = lg_f(starve_limit_p + 1);
  localparam logic [cnt_w_lp-1:0]    els_lp        = cnt_w_lp'(els_p);
  localparam logic [starve_w_lp-1:0] starve_max_lp = starve_w_lp'(starve_limit_p);

  logic [cnt_w_lp-1:0]    count_q, count_d;
  logic [starve_w_lp-1:0] starve_q, starve_d;
  logic                   full_q, empty_q, deq_v_q;
  logic [addr_w_lp-1:0]   wr_ptr, rd_ptr;
  logic                   wr_req, rd_req;
  op_e                    op;

  assign wr_req = io.enq_v_i & ~full_q;
  assign rd_req = io.deq_ready_i & ~empty_q;

  bsg_fifo_1rw_wrap_ptr #(.els_p(els_p)) wr_ptr_u (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .inc_i(op == OP_WRITE), .ptr_o(wr_ptr)
  );

  bsg_fifo_1rw_wrap_ptr #(.els_p(els_p)) rd_ptr_u (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .inc_i(op == OP_READ), .ptr_o(rd_ptr)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q  <= '0;
      starve_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      deq_v_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      starve_q <= starve_d;
      full_q   <= (count_d == els_lp);
      empty_q  <= (count_d == '0);
      deq_v_q  <= (op == OP_READ);
    end
  end

  // Writes win ties until the read side has been denied starve_limit_p times in a row.
  always_comb begin
    op       = OP_NONE;
    count_d  = count_q;
    starve_d = starve_q;
    if (reset_n_i) begin
      if (rd_req && (!wr_req || starve_q == starve_max_lp)) op = OP_READ;
      else if (wr_req)                                      op = OP_WRITE;
    end
    if (op == OP_WRITE)     count_d = count_q + cnt_w_lp'(1);
    else if (op == OP_READ) count_d = count_q - cnt_w_lp'(1);
    if (op == OP_READ || !rd_req)       starve_d = '0;
    else if (starve_q != starve_max_lp) starve_d = starve_q + starve_w_lp'(1);
  end

  assign io.enq_yumi_o = (op == OP_WRITE);
  assign io.mem_v_o    = (op != OP_NONE);
  assign io.mem_w_o    = (op == OP_WRITE);
  assign io.mem_addr_o = (op == OP_WRITE) ? wr_ptr : rd_ptr;
  assign io.mem_data_o = io.enq_data_i;
  assign io.deq_v_o    = deq_v_q;
  assign io.deq_data_o = io.mem_data_i;
  assign io.full_o     = full_q;
  assign io.empty_o    = empty_q;

  always_ff @(posedge clk_i) begin
    if (reset_n_i) assert (count_q <= els_lp);
  end
endmodule

// File: tb/tb_bsg_fifo_1rw_sched.sv
// tb/tb_bsg_fifo_1rw_sched.sv - randomized scoreboard bench for bsg_fifo_1rw_sched
module tb_bsg_fifo_1rw_sched;
  import bsg_fifo_1rw_pkg::*;

  localparam int ELS = 8;
  localparam int W   = 16;
  localparam int SL  = 4;
  localparam int AW  = lg_f(ELS);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bsg_fifo_1rw_sched_if #(.width_p(W), .addr_w_p(AW)) io ();

  bsg_fifo_1rw_sched #(.els_p(ELS), .width_p(W), .starve_limit_p(SL)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .io(io)
  );

  logic [W-1:0] sram [ELS];
  logic [W-1:0] sram_rd = '0;
  always @(posedge clk) begin
    if (io.mem_v_o) begin
      if (io.mem_w_o) sram[io.mem_addr_o] <= io.mem_data_o;
      else            sram_rd <= sram[io.mem_addr_o];
    end
  end
  assign io.mem_data_i = sram_rd;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] mq[$];
  logic [W-1:0] sb[$];
  logic [W-1:0] m_exp;
  int starve, wcnt, rcnt;
  bit prev_rd;
  string seq;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    sb.delete();
    starve = 0;
    wcnt = 0;
    rcnt = 0;
    prev_rd = 1'b0;
  endtask

  always @(negedge clk) begin
    if (io.deq_v_o) begin
      if (sb.size() == 0) chk("deq_v_extra", 32'(io.deq_v_o), 32'd0);
      else begin
        m_exp = sb.pop_front();
        chk("deq_data", 32'(io.deq_data_o), 32'(m_exp));
      end
    end
  end

  task automatic step(input bit ev, input logic [W-1:0] ed, input bit dr);
    bit wr_req, rd_req;
    op_e op;
    @(posedge clk); #1;
    io.enq_v_i = ev;
    io.enq_data_i = ed;
    io.deq_ready_i = dr;
    @(negedge clk); #1;
    chk("deq_v", 32'(io.deq_v_o), 32'(prev_rd));
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("empty", 32'(io.empty_o), 32'(mq.size() == 0));
    chk("full", 32'(io.full_o), 32'(mq.size() == ELS));
    wr_req = ev && (mq.size() < ELS);
    rd_req = dr && (mq.size() > 0);
    if (rd_req && (!wr_req || starve == SL)) op = OP_READ;
    else if (wr_req)                         op = OP_WRITE;
    else                                     op = OP_NONE;
    seq = {seq, io.mem_v_o ? (io.mem_w_o ? "W" : "R") : "-"};
    chk("mem_v", 32'(io.mem_v_o), 32'(op != OP_NONE));
    chk("enq_yumi", 32'(io.enq_yumi_o), 32'(op == OP_WRITE));
    if (op == OP_WRITE) begin
      chk("mem_w", 32'(io.mem_w_o), 32'd1);
      chk("wr_addr", 32'(io.mem_addr_o), 32'(wcnt % ELS));
      chk("mem_data", 32'(io.mem_data_o), 32'(ed));
      mq.push_back(ed);
      wcnt++;
    end else if (op == OP_READ) begin
      chk("mem_w", 32'(io.mem_w_o), 32'd0);
      chk("rd_addr", 32'(io.mem_addr_o), 32'(rcnt % ELS));
      sb.push_back(mq.pop_front());
      rcnt++;
    end
    if (op == OP_READ || !rd_req) starve = 0;
    else if (starve < SL)         starve++;
    prev_rd = (op == OP_READ);
  endtask

  task automatic strings_chk(input string nm, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %s expected %s", nm, act, exp);
    end
  endtask

  initial begin
    int pe, pd;
    io.enq_v_i = 1'b1;
    io.enq_data_i = '0;
    io.deq_ready_i = 1'b1;
    model_clear();
    @(posedge clk); #1;
    chk("rst_yumi", 32'(io.enq_yumi_o), 32'd0);
    chk("rst_mem_v", 32'(io.mem_v_o), 32'd0);
    chk("rst_deq_v", 32'(io.deq_v_o), 32'd0);
    chk("rst_empty", 32'(io.empty_o), 32'd1);
    chk("rst_full", 32'(io.full_o), 32'd0);
    io.enq_v_i = 1'b0;
    io.deq_ready_i = 1'b0;
    rst_n = 1'b1;

    // writes A,B,C with no consumer, then drain them
    step(1'b1, 16'hA00A, 1'b0);
    step(1'b1, 16'hB00B, 1'b0);
    step(1'b1, 16'hC00C, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

    // fill to full, push against full, free a slot, refill
    for (int i = 0; i < ELS + 2; i++) step(1'b1, W'($urandom), 1'b0);
    step(1'b1, W'($urandom), 1'b1);
    step(1'b1, W'($urandom), 1'b0);
    for (int i = 0; i < ELS + 2; i++) step(1'b0, '0, 1'b1);

    // both sides busy from empty: reads get in only after SL denials
    seq = "";
    for (int i = 0; i < 10; i++) step(1'b1, W'($urandom), 1'b1);
    strings_chk("starve_pattern", seq, "WWWWWRWWWW");

    // reset while a read response is due
    step(1'b0, '0, 1'b1);
    @(posedge clk); #1;
    chk("pre_rst_deq_v", 32'(io.deq_v_o), 32'd1);
    rst_n = 1'b0;
    io.enq_v_i = 1'b0;
    io.deq_ready_i = 1'b0;
    #1;
    chk("async_rst_deq_v", 32'(io.deq_v_o), 32'd0);
    chk("async_rst_empty", 32'(io.empty_o), 32'd1);
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b1, 16'h5A5A, 1'b0);
    step(1'b0, '0, 1'b1);

    // random traffic with varying bias
    for (int i = 0; i < 10000; i++) begin
      if (i % 500 == 0) begin
        pe = $urandom_range(10, 95);
        pd = $urandom_range(10, 95);
      end
      step(($urandom_range(0, 99) < pe), W'($urandom), ($urandom_range(0, 99) < pd));
    end
    for (int i = 0; i < ELS + 2; i++) step(1'b0, '0, 1'b1);
    chk("final_model_empty", 32'(mq.size()), 32'd0);
    chk("final_empty", 32'(io.empty_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
